// File: rtl/prio_rr_arbiter_starve.sv
// rtl/prio_rr_arbiter_starve.sv - two-class round-robin arbiter with starvation guard, go timeout and protocol-error flags
module prio_rr_arbiter_starve #(
  parameter int NUM_H      = 2,
  parameter int NUM_L      = 4,
  parameter int CH_W       = 4,
  parameter int STARVE_MAX = 3,
  parameter int GO_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_H-1:0] bool_ready_H,
  input  logic [NUM_H-1:0] bool_go_H,
  input  logic [NUM_L-1:0] bool_ready_L,
  input  logic [NUM_L-1:0] bool_go_L,
  output logic [NUM_H-1:0] ena_n_H,
  output logic [NUM_L-1:0] ena_n_L,
  output logic [1:0]       active,
  output logic [CH_W-1:0]  channel,
  output logic [2:0]       starve_cnt,
  output logic             timeout_err,
  output logic             proto_err
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [NUM_H-1:0] ena_n_h_q, ena_n_h_d;
  logic [NUM_L-1:0] ena_n_l_q, ena_n_l_d;
  logic [1:0]       active_q, active_d;
  logic [CH_W-1:0]  channel_q, channel_d;
  logic [2:0]       starve_q, starve_d;
  logic             tmo_q, tmo_d;
  logic             proto_q, proto_d;
  logic [CH_W-1:0]  ptr_h_q, ptr_h_d;
  logic [CH_W-1:0]  ptr_l_q, ptr_l_d;
  logic [7:0]       wait_q, wait_d;

  logic             any_h, any_l, force_l, gnt_go, gnt_rdy;
  logic [CH_W-1:0]  pick_h, pick_l, ptr_inc_h, ptr_inc_l;
  logic [NUM_H-1:0] win_n_h;
  logic [NUM_L-1:0] win_n_l;
  int               dist_h, best_h, dist_l, best_l;

  assign any_h   = |bool_ready_H;
  assign any_l   = |bool_ready_L;
  assign force_l = (STARVE_MAX != 0) && (int'(starve_q) == STARVE_MAX) && any_l;

  // The enable vectors are one-cold while granted, so they double as grant masks.
  assign gnt_go  = (|(bool_go_H & ~ena_n_h_q)) || (|(bool_go_L & ~ena_n_l_q));
  assign gnt_rdy = (|(bool_ready_H & ~ena_n_h_q)) || (|(bool_ready_L & ~ena_n_l_q));

  assign ptr_inc_h = (int'(channel_q) >= NUM_H - 1) ? '0 : channel_q + 1'b1;
  assign ptr_inc_l = (int'(channel_q) >= NUM_L - 1) ? '0 : channel_q + 1'b1;

  // Winner is the ready channel with the smallest wrapped distance from the pointer.
  always_comb begin
    pick_h = '0;
    best_h = NUM_H;
    dist_h = 0;
    for (int i = 0; i < NUM_H; i++) begin
      dist_h = i - int'(ptr_h_q);
      if (dist_h < 0) dist_h = dist_h + NUM_H;
      if (bool_ready_H[i] && (dist_h < best_h)) begin
        best_h = dist_h;
        pick_h = CH_W'(i);
      end
    end
    win_n_h = '1;
    for (int i = 0; i < NUM_H; i++) begin
      if (pick_h == CH_W'(i)) win_n_h[i] = 1'b0;
    end
  end

  always_comb begin
    pick_l = '0;
    best_l = NUM_L;
    dist_l = 0;
    for (int i = 0; i < NUM_L; i++) begin
      dist_l = i - int'(ptr_l_q);
      if (dist_l < 0) dist_l = dist_l + NUM_L;
      if (bool_ready_L[i] && (dist_l < best_l)) begin
        best_l = dist_l;
        pick_l = CH_W'(i);
      end
    end
    win_n_l = '1;
    for (int i = 0; i < NUM_L; i++) begin
      if (pick_l == CH_W'(i)) win_n_l[i] = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    ena_n_h_d = ena_n_h_q;
    ena_n_l_d = ena_n_l_q;
    active_d  = active_q;
    channel_d = channel_q;
    starve_d  = starve_q;
    ptr_h_d   = ptr_h_q;
    ptr_l_d   = ptr_l_q;
    wait_d    = '0;
    tmo_d     = 1'b0;
    proto_d   = (|(bool_go_H & ena_n_h_q)) || (|(bool_go_L & ena_n_l_q));
    case (state_q)
      S_IDLE: begin
        if (any_h && !force_l) begin
          state_d   = S_GRANT;
          active_d  = 2'b01;
          channel_d = pick_h;
          ena_n_h_d = win_n_h;
        end else if (any_l) begin
          state_d   = S_GRANT;
          active_d  = 2'b10;
          channel_d = pick_l;
          ena_n_l_d = win_n_l;
        end
      end
      S_GRANT: begin
        if (gnt_go) begin
          state_d = S_BUSY;
        end else if (!gnt_rdy) begin
          state_d   = S_IDLE;
          ena_n_h_d = '1;
          ena_n_l_d = '1;
          active_d  = 2'b00;
        end else if (int'(wait_q) + 1 >= GO_TIMEOUT) begin
          state_d   = S_GAP;
          tmo_d     = 1'b1;
          ena_n_h_d = '1;
          ena_n_l_d = '1;
          active_d  = 2'b00;
          if (active_q == 2'b01) ptr_h_d = ptr_inc_h;
          else ptr_l_d = ptr_inc_l;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_BUSY: begin
        if (!gnt_go) begin
          state_d   = S_GAP;
          ena_n_h_d = '1;
          ena_n_l_d = '1;
          active_d  = 2'b00;
          if (active_q == 2'b01) begin
            ptr_h_d = ptr_inc_h;
            if (any_l && (int'(starve_q) < STARVE_MAX)) starve_d = starve_q + 3'd1;
          end else begin
            ptr_l_d  = ptr_inc_l;
            starve_d = '0;
          end
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ena_n_h_q <= '1;
      ena_n_l_q <= '1;
      active_q  <= 2'b00;
      channel_q <= '0;
      starve_q  <= '0;
      tmo_q     <= 1'b0;
      proto_q   <= 1'b0;
      ptr_h_q   <= '0;
      ptr_l_q   <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      ena_n_h_q <= ena_n_h_d;
      ena_n_l_q <= ena_n_l_d;
      active_q  <= active_d;
      channel_q <= channel_d;
      starve_q  <= starve_d;
      tmo_q     <= tmo_d;
      proto_q   <= proto_d;
      ptr_h_q   <= ptr_h_d;
      ptr_l_q   <= ptr_l_d;
      wait_q    <= wait_d;
    end
  end

  assign ena_n_H     = ena_n_h_q;
  assign ena_n_L     = ena_n_l_q;
  assign active      = active_q;
  assign channel     = channel_q;
  assign starve_cnt  = starve_q;
  assign timeout_err = tmo_q;
  assign proto_err   = proto_q;

endmodule
